// File: rtl/ft_recovery_loader.sv
// Rollback recovery loader: reads checkpointed x1..x31 and the PC from safe memory
// and replays them into the core register file and PC reload port.
module ft_recovery_loader #(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MAX_RETRY  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  recover_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  input  logic                  data_err_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  pc_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o
);

  // state | meaning
  // IDLE  | waiting for recover_i
  // REQ   | read request held until granted
  // WAIT  | one read outstanding, waiting for rvalid
  // WB    | replay captured word to register file or PC
  // DONE  | walk finished, wait for recover_i to drop
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // One extra index bit so the PC slot (2**ADDR_WIDTH) is reachable without wrapping.
  localparam int IW = ADDR_WIDTH + 1;
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [IW-1:0] PC_IDX = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [2:0]            state;
  logic [IW-1:0]         idx;
  logic [RW-1:0]         retry;
  logic                  done_q;
  logic                  fail_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  is_pc;

  assign is_pc = (idx == PC_IDX);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      idx     <= IW'(1);
      retry   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (recover_i) begin
            state  <= S_REQ;
            idx    <= IW'(1);
            retry  <= '0;
            fail_q <= 1'b0;
          end
        end
        S_REQ: begin
          if (data_gnt_i) state <= S_WAIT;
        end
        S_WAIT: begin
          if (data_rvalid_i) begin
            if (!data_err_i) begin
              state <= S_WB;
              if (is_pc) begin
                pc_q <= data_rdata_i;
              end else begin
                wdata_q <= data_rdata_i;
                waddr_q <= idx[ADDR_WIDTH-1:0];
              end
            end else if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              state <= S_REQ;
            end else begin
              fail_q <= 1'b1;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_WB: begin
          idx   <= idx + 1'b1;
          retry <= '0;
          if (is_pc) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            state <= S_REQ;
          end
        end
        S_DONE: begin
          // A held start request must not restart the walk.
          if (!recover_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign data_req_o  = (state == S_REQ);
  assign data_addr_o = data_req_o ? (BASE_ADDR + {{(32-IW-2){1'b0}}, idx, 2'b00}) : 32'h0;
  assign data_we_o   = 1'b0;
  assign data_be_o   = 4'hF;

  assign rf_we_o    = (state == S_WB) && !is_pc;
  assign pc_valid_o = (state == S_WB) && is_pc;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;
  assign pc_o       = pc_q;
  assign busy_o     = (state == S_REQ) || (state == S_WAIT) || (state == S_WB);
  assign done_o     = done_q;
  assign fail_o     = fail_q;

endmodule

// File: tb/tb_ft_recovery_loader.sv
// Directed bench for ft_recovery_loader with a behavioural safe-memory responder.
module tb_ft_recovery_loader;
  localparam int          AW   = 5;
  localparam int          DW   = 32;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic          clk_i;
  logic          rst_ni;
  logic          recover_i;
  logic          data_req_o;
  logic          data_gnt_i;
  logic [31:0]   data_addr_o;
  logic          data_we_o;
  logic [3:0]    data_be_o;
  logic          data_rvalid_i;
  logic [DW-1:0] data_rdata_i;
  logic          data_err_i;
  logic          rf_we_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic [DW-1:0] pc_o;
  logic          pc_valid_o;
  logic          busy_o;
  logic          done_o;
  logic          fail_o;

  ft_recovery_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .MAX_RETRY(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .recover_i(recover_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory responder: grant after gnt_delay request cycles, data one cycle after grant.
  int          gnt_delay;
  int          err_idx, err_n, err_base;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;
  logic        man_rvalid;
  logic [31:0] man_rdata;
  int          grants [0:32];
  int          resp   [0:32];

  assign data_gnt_i    = mem_gnt;
  assign data_rvalid_i = mem_rvalid | man_rvalid;
  assign data_rdata_i  = man_rvalid ? man_rdata : mem_rdata;
  assign data_err_i    = mem_err & mem_rvalid;

  function automatic logic [31:0] word_at(input int i);
    return (i == 32) ? 32'h0000_0200 : (32'hA000_0000 + 32'(i));
  endfunction

  initial begin
    bit pend;
    int pend_idx;
    int wait_cnt;
    pend = 0; pend_idx = 0; wait_cnt = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
    for (int i = 0; i < 33; i++) begin grants[i] = 0; resp[i] = 0; end
    forever begin
      @(posedge clk_i); #1;
      mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
      if (pend) begin
        mem_rvalid = 1;
        mem_rdata  = word_at(pend_idx);
        if (pend_idx == err_idx && (resp[pend_idx] - err_base) < err_n) mem_err = 1;
        resp[pend_idx]++;
        pend = 0;
      end
      if (data_req_o) begin
        if (wait_cnt >= gnt_delay) begin
          mem_gnt  = 1;
          pend_idx = int'((data_addr_o - BASE) >> 2);
          if (pend_idx > 32) pend_idx = 32;
          grants[pend_idx]++;
          pend     = 1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Observation logs, sampled mid-cycle.
  logic [AW-1:0] we_addr_q [$];
  logic [DW-1:0] we_data_q [$];
  int            x0_cnt = 0, both_cnt = 0, pc_cnt = 0, done_cnt = 0, done_cyc = 0, stab_err = 0;
  logic [DW-1:0] last_pc = '0;
  logic          done_fail = 1'b0;
  logic          prev_req = 1'b0, prev_gnt = 1'b0;
  logic [31:0]   prev_addr = '0;

  always @(negedge clk_i) begin
    if (rf_we_o) begin
      we_addr_q.push_back(rf_waddr_o);
      we_data_q.push_back(rf_wdata_o);
      if (rf_waddr_o == '0) x0_cnt++;
    end
    if (pc_valid_o) begin pc_cnt++; last_pc = pc_o; end
    if (rf_we_o && pc_valid_o) both_cnt++;
    if (done_o) begin done_cnt++; done_cyc = cyc; done_fail = fail_o; end
    if (prev_req && !prev_gnt && rst_ni)
      if (!data_req_o || data_addr_o != prev_addr) stab_err++;
    prev_req  = data_req_o;
    prev_gnt  = data_gnt_i;
    prev_addr = data_addr_o;
  end

  task automatic start_pulse(output int s);
    @(negedge clk_i); recover_i = 1'b1;
    @(posedge clk_i); #1; s = cyc;
    @(negedge clk_i); recover_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i); #1;
      if (done_cnt > d0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({data_req_o, data_addr_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_o, pc_valid_o, busy_o, done_o, fail_o} !== 107'd0) begin
      errors++; $display("FAIL reset_outputs got req=%b addr=%h we=%b pcv=%b busy=%b done=%b fail=%b, want all 0",
                         data_req_o, data_addr_o, rf_we_o, pc_valid_o, busy_o, done_o, fail_o);
    end
    checks++;
    if (data_we_o !== 1'b0 || data_be_o !== 4'hF) begin
      errors++; $display("FAIL tie_offs got we=%b be=%h, want 0/f", data_we_o, data_be_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_walk(input int delay, input int exp_lat);
    int s, w0, d0, x0, b0, p0, st0, bad;
    int g0 [0:32];
    bit ok;
    gnt_delay = delay;
    w0 = we_addr_q.size(); d0 = done_cnt; x0 = x0_cnt; b0 = both_cnt; p0 = pc_cnt; st0 = stab_err;
    for (int i = 0; i < 33; i++) g0[i] = grants[i];
    start_pulse(s);
    wait_done(d0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL walk%0d_timeout no done_o, want done", delay); end
    checks++;
    if (done_cyc - s != exp_lat) begin
      errors++; $display("FAIL walk%0d_latency got %0d want %0d", delay, done_cyc - s, exp_lat);
    end
    checks++;
    if (we_addr_q.size() - w0 != 31) begin
      errors++; $display("FAIL walk%0d_writes got %0d want 31", delay, we_addr_q.size() - w0);
    end
    bad = 0;
    for (int i = 0; i < 31 && (w0 + i) < we_addr_q.size(); i++)
      if (we_addr_q[w0+i] != AW'(i + 1) || we_data_q[w0+i] != word_at(i + 1)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL walk%0d_order got %0d bad entries want 0", delay, bad); end
    checks++;
    if (pc_cnt - p0 != 1 || last_pc !== 32'h0000_0200) begin
      errors++; $display("FAIL walk%0d_pc got cnt=%0d pc=%h want 1/00000200", delay, pc_cnt - p0, last_pc);
    end
    checks++;
    if (done_fail !== 1'b0 || x0_cnt != x0 || both_cnt != b0) begin
      errors++; $display("FAIL walk%0d_clean got fail=%b x0=%0d both=%0d want 0/0/0", delay, done_fail, x0_cnt - x0, both_cnt - b0);
    end
    bad = 0;
    for (int i = 1; i < 33; i++) if (grants[i] - g0[i] != 1) bad++;
    checks++;
    if (bad != 0 || grants[0] != g0[0] || stab_err != st0) begin
      errors++; $display("FAIL walk%0d_requests got %0d bad words, %0d unstable cycles, want 0/0", delay, bad, stab_err - st0);
    end
    gnt_delay = 0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_retry;
    int s, w0, d0, g7, n7;
    bit ok;
    w0 = we_addr_q.size(); d0 = done_cnt; g7 = grants[7];
    err_idx = 7; err_base = resp[7]; err_n = 1;
    start_pulse(s);
    wait_done(d0, ok);
    checks++;
    if (!ok || done_cyc - s != 98) begin
      errors++; $display("FAIL retry_latency got ok=%0d lat=%0d want 1/98", ok, done_cyc - s);
    end
    checks++;
    if (grants[7] - g7 != 2) begin errors++; $display("FAIL retry_reqs got %0d want 2", grants[7] - g7); end
    n7 = 0;
    for (int i = w0; i < we_addr_q.size(); i++) if (we_addr_q[i] == AW'(7)) n7++;
    checks++;
    if (n7 != 1 || we_addr_q.size() - w0 != 31 || we_data_q[w0+6] !== 32'hA000_0007) begin
      errors++; $display("FAIL retry_x7 got n=%0d total=%0d data=%h want 1/31/a0000007", n7, we_addr_q.size() - w0, we_data_q[w0+6]);
    end
    checks++;
    if (done_fail !== 1'b0) begin errors++; $display("FAIL retry_fail got %b want 0", done_fail); end
    err_n = 0; err_idx = -1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_fail;
    int s, w0, d0, p0, g12;
    bit ok;
    w0 = we_addr_q.size(); d0 = done_cnt; p0 = pc_cnt; g12 = grants[12];
    err_idx = 12; err_base = resp[12]; err_n = 3;
    start_pulse(s);
    wait_done(d0, ok);
    checks++;
    if (!ok || done_cyc - s != 39 || done_fail !== 1'b1) begin
      errors++; $display("FAIL fail_done got ok=%0d lat=%0d fail=%b want 1/39/1", ok, done_cyc - s, done_fail);
    end
    checks++;
    if (grants[12] - g12 != 3) begin errors++; $display("FAIL fail_reqs got %0d want 3", grants[12] - g12); end
    checks++;
    if (we_addr_q.size() - w0 != 11 || we_addr_q[we_addr_q.size()-1] != AW'(11) || pc_cnt != p0) begin
      errors++; $display("FAIL fail_writes got n=%0d last=%0d pc=%0d want 11/11/0",
                         we_addr_q.size() - w0, we_addr_q[we_addr_q.size()-1], pc_cnt - p0);
    end
    err_n = 0; err_idx = -1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (fail_o !== 1'b1) begin errors++; $display("FAIL fail_sticky got %b want 1", fail_o); end
    d0 = done_cnt;
    start_pulse(s);
    checks++;
    if (fail_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL fail_clear got fail=%b busy=%b want 0/1", fail_o, busy_o);
    end
    wait_done(d0, ok);
    checks++;
    if (!ok || done_fail !== 1'b0) begin errors++; $display("FAIL fail_rerun got ok=%0d fail=%b want 1/0", ok, done_fail); end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset_mid;
    int s, w0, w1, d0;
    bit ok;
    w0 = we_addr_q.size();
    start_pulse(s);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i); #1;
      if (we_addr_q.size() >= w0 + 10) begin ok = 1; break; end
    end
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (!ok || {data_req_o, data_addr_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_o, pc_valid_o, busy_o, done_o, fail_o} !== 107'd0) begin
      errors++; $display("FAIL midreset_outputs got seen=%0d req=%b we=%b waddr=%0d wdata=%h busy=%b, want 1/all 0",
                         ok, data_req_o, rf_we_o, rf_waddr_o, rf_wdata_o, busy_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    man_rdata = 32'hDEAD_BEEF; man_rvalid = 1'b1;
    @(negedge clk_i); man_rvalid = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (we_addr_q.size() - w0 != 10 || busy_o !== 1'b0) begin
      errors++; $display("FAIL midreset_late got writes=%0d busy=%b want 10/0", we_addr_q.size() - w0, busy_o);
    end
    w1 = we_addr_q.size(); d0 = done_cnt;
    start_pulse(s);
    wait_done(d0, ok);
    checks++;
    if (!ok || we_addr_q.size() - w1 != 31 || we_addr_q[w1] != AW'(1) || we_data_q[w1] !== 32'hA000_0001) begin
      errors++; $display("FAIL midreset_restart got ok=%0d n=%0d first=%0d/%h want 1/31/1/a0000001",
                         ok, we_addr_q.size() - w1, we_addr_q[w1], we_data_q[w1]);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_hold;
    int s, w0, d0;
    bit ok;
    w0 = we_addr_q.size(); d0 = done_cnt;
    @(negedge clk_i); recover_i = 1'b1;
    @(posedge clk_i); #1; s = cyc;
    repeat (199) @(negedge clk_i);
    checks++;
    if (done_cnt - d0 != 1 || we_addr_q.size() - w0 != 31 || done_cyc - s != 96 || busy_o !== 1'b0) begin
      errors++; $display("FAIL hold_single got done=%0d writes=%0d lat=%0d busy=%b want 1/31/96/0",
                         done_cnt - d0, we_addr_q.size() - w0, done_cyc - s, busy_o);
    end
    recover_i = 1'b0;
    repeat (2) @(negedge clk_i);
    d0 = done_cnt;
    start_pulse(s);
    wait_done(d0, ok);
    checks++;
    if (!ok || done_cyc - s != 96) begin
      errors++; $display("FAIL hold_release got ok=%0d lat=%0d want 1/96", ok, done_cyc - s);
    end
  endtask

  initial begin
    rst_ni = 1'b0; recover_i = 1'b0;
    gnt_delay = 0; err_idx = -1; err_n = 0; err_base = 0;
    man_rvalid = 1'b0; man_rdata = '0;
    test_reset;
    test_walk(0, 96);
    test_walk(3, 192);
    test_retry;
    test_fail;
    test_reset_mid;
    test_hold;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
